// File: rtl/rv_dmem_arb.sv
// Data-memory port arbiter: core pipeline vs. external (debug/loader) requester.
// Bounded external wait via a saturating starvation counter; read data is steered back to the issuer.
package rv_dmem_pkg;
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wr_data;
        logic [3:0]  byte_en;
        logic        wr_en;
        logic        rd_en;
    } t_core2mem_req;
endpackage

module rv_dmem_arb
    import rv_dmem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  t_core2mem_req core2dmem_req_Q103H,
    input  t_core2mem_req ext_req,
    output logic          ext_gnt,
    output t_core2mem_req arb2dmem_req,
    input  logic [31:0]   dmem_rd_data,
    output logic          core_ready_Q104H,
    output logic [31:0]   core_rd_data_Q104H,
    output logic          ext_rd_valid,
    output logic [31:0]   ext_rd_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } t_owner;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic        core_vld, ext_vld, ext_win;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    t_owner      rd_owner_q, rd_owner_d;
    logic [31:0] core_rd_hold_q, ext_rd_hold_q;

    always_comb begin
        core_vld = core2dmem_req_Q103H.rd_en | core2dmem_req_Q103H.wr_en;
        ext_vld  = ext_req.rd_en | ext_req.wr_en;
        // External wins when alone, or when it has lost STARVE_MAX cycles in a row.
        ext_win  = rst && ext_vld && (!core_vld || starve_cnt_q == STARVE_LIM);

        arb2dmem_req = '0;
        if (ext_win)
            arb2dmem_req = ext_req;
        else if (core_vld)
            arb2dmem_req = core2dmem_req_Q103H;
        if (!rst) begin
            arb2dmem_req.wr_en = 1'b0;
            arb2dmem_req.rd_en = 1'b0;
        end

        ext_gnt          = ext_win;
        core_ready_Q104H = !(core_vld && ext_win);

        starve_cnt_d = starve_cnt_q;
        if (!ext_vld || ext_win)
            starve_cnt_d = '0;
        else if (starve_cnt_q < STARVE_LIM)
            starve_cnt_d = starve_cnt_q + 4'd1;

        rd_owner_d = OWN_NONE;
        if (arb2dmem_req.rd_en)
            rd_owner_d = ext_win ? OWN_EXT : OWN_CORE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q   <= '0;
            rd_owner_q     <= OWN_NONE;
            core_rd_hold_q <= '0;
            ext_rd_hold_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_owner_q   <= rd_owner_d;
            if (rd_owner_q == OWN_CORE)
                core_rd_hold_q <= dmem_rd_data;
            if (rd_owner_q == OWN_EXT)
                ext_rd_hold_q <= dmem_rd_data;
        end
    end

    // Returned data is live in the return cycle and held afterwards.
    assign ext_rd_valid       = (rd_owner_q == OWN_EXT);
    assign ext_rd_data        = ext_rd_valid ? dmem_rd_data : ext_rd_hold_q;
    assign core_rd_data_Q104H = (rd_owner_q == OWN_CORE) ? dmem_rd_data : core_rd_hold_q;

endmodule

// File: tb/tb_rv_dmem_arb.sv
// Bench for rv_dmem_arb: directed vector table, reset corner cases, and randomized traffic
// checked against a transaction-level model with its own copy of memory.
module tb_rv_dmem_arb;
    import rv_dmem_pkg::*;

    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    t_core2mem_req creq, ereq, arb;
    logic          ext_gnt, core_ready, ext_rd_valid;
    logic [31:0]   dmem_rd_data, core_rd, ext_rd;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    rv_dmem_arb #(.STARVE_MAX(SM)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .core2dmem_req_Q103H (creq),
        .ext_req             (ereq),
        .ext_gnt             (ext_gnt),
        .arb2dmem_req        (arb),
        .dmem_rd_data        (dmem_rd_data),
        .core_ready_Q104H    (core_ready),
        .core_rd_data_Q104H  (core_rd),
        .ext_rd_valid        (ext_rd_valid),
        .ext_rd_data         (ext_rd)
    );

    // Single-ported synchronous memory: read data one cycle after issue.
    always @(posedge clk) begin
        if (arb.rd_en) dmem_rd_data <= mem[arb.address[9:2]];
        if (arb.wr_en)
            for (int b = 0; b < 4; b++)
                if (arb.byte_en[b]) mem[arb.address[9:2]][8*b +: 8] <= arb.wr_data[8*b +: 8];
    end

    // ---------------- reference model ----------------
    int            m_lost, m_owner;      // owner: 0 none, 1 core, 2 ext
    logic [31:0]   m_rdata, m_chold, m_ehold;
    bit            x_eg, x_rdy, x_ev, x_evin;
    t_core2mem_req x_win;
    logic [31:0]   x_cd, x_ed;

    function automatic bit is_v(t_core2mem_req r);
        return r.rd_en | r.wr_en;
    endfunction

    function automatic t_core2mem_req mk(bit rd, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        t_core2mem_req r;
        r = '0;
        r.rd_en = rd; r.wr_en = wr; r.address = a; r.wr_data = d; r.byte_en = be;
        return r;
    endfunction

    task automatic model_reset();
        m_lost = 0; m_owner = 0; m_rdata = '0; m_chold = '0; m_ehold = '0;
    endtask

    task automatic model_eval();
        bit cv;
        cv     = is_v(creq);
        x_evin = is_v(ereq);
        x_eg   = x_evin && (!cv || m_lost == SM);
        x_win  = x_eg ? ereq : (cv ? creq : '0);
        x_rdy  = !(cv && x_eg);
        x_cd   = (m_owner == 1) ? m_rdata : m_chold;
        x_ev   = (m_owner == 2);
        x_ed   = x_ev ? m_rdata : m_ehold;
    endtask

    task automatic model_commit();
        int idx;
        if (m_owner == 1) m_chold = m_rdata;
        if (m_owner == 2) m_ehold = m_rdata;
        idx = int'(x_win.address[9:2]);
        if (x_win.rd_en) begin
            m_rdata = ref_mem[idx];
            m_owner = x_eg ? 2 : 1;
        end else
            m_owner = 0;
        if (x_win.wr_en)
            for (int b = 0; b < 4; b++)
                if (x_win.byte_en[b]) ref_mem[idx][8*b +: 8] = x_win.wr_data[8*b +: 8];
        if (!x_evin || x_eg) m_lost = 0;
        else if (m_lost < SM) m_lost = m_lost + 1;
    endtask

    task automatic chk(string n, logic [69:0] a, logic [69:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".ext_gnt"},    70'(ext_gnt),      70'(x_eg));
        chk({tag, ".core_ready"}, 70'(core_ready),   70'(x_rdy));
        chk({tag, ".arb_req"},    70'(arb),          70'(x_win));
        chk({tag, ".core_rd"},    70'(core_rd),      70'(x_cd));
        chk({tag, ".ext_vld"},    70'(ext_rd_valid), 70'(x_ev));
        chk({tag, ".ext_rd"},     70'(ext_rd),       70'(x_ed));
    endtask

    // one cycle: inputs already driven at posedge+1; check before next edge
    task automatic cycle(string tag);
        #4;
        model_eval();
        check_all(tag);
        model_commit();
        @(posedge clk); #1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        t_core2mem_req c, e;
        bit            gnt, rdy, evld;
        logic [31:0]   cd, ed;
    } vec_t;
    vec_t tbl[$];

    function automatic t_core2mem_req core_of(int k);
        case (k)
            1:       return mk(1, 0, 32'h100, 32'h0, 4'hF);
            2:       return mk(1, 0, 32'h010, 32'h0, 4'hF);
            3:       return mk(0, 1, 32'h200, 32'h55AA55AA, 4'hF);
            default: return '0;
        endcase
    endfunction

    function automatic t_core2mem_req ext_of(int k);
        case (k)
            1:       return mk(0, 1, 32'h040, 32'h12345678, 4'hF);
            2:       return mk(1, 0, 32'h040, 32'h0, 4'hF);
            3:       return mk(1, 0, 32'h014, 32'h0, 4'hF);
            default: return '0;
        endcase
    endfunction

    task automatic add(int ck, int ek, bit g, bit r, logic [31:0] cd, bit ev, logic [31:0] ed);
        vec_t v;
        v.c = core_of(ck); v.e = ext_of(ek);
        v.gnt = g; v.rdy = r; v.cd = cd; v.evld = ev; v.ed = ed;
        tbl.push_back(v);
    endtask

    function automatic t_core2mem_req rnd_req(int pct);
        t_core2mem_req r;
        int k;
        if (int'($urandom_range(0, 99)) >= pct) return '0;
        k = int'($urandom_range(0, 9));
        r = mk(k < 5 || k == 9, k >= 5, 32'h300 + 32'($urandom_range(0, 15)) * 4,
               $urandom, 4'($urandom_range(1, 15)));
        return r;
    endfunction

    initial begin
        t_core2mem_req rc, re;
        bit last_rdy, last_eg;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = (32'(i) * 32'h01010101) ^ 32'hC3C30000;
            ref_mem[i] = mem[i];
        end
        mem[64] = 32'hDEADBEEF; ref_mem[64] = 32'hDEADBEEF;
        mem[4]  = 32'hAAAA0000; ref_mem[4]  = 32'hAAAA0000;
        mem[5]  = 32'hBBBB0000; ref_mem[5]  = 32'hBBBB0000;

        // reset: both requesting, nothing may be granted or issued
        creq = core_of(1); ereq = ext_of(3);
        #2;
        chk("rst.ext_gnt",    70'(ext_gnt),    70'(0));
        chk("rst.core_ready", 70'(core_ready), 70'(1));
        chk("rst.enables",    70'({arb.rd_en, arb.wr_en}), 70'(0));
        @(posedge clk); #1;
        chk("rst.core_rd", 70'(core_rd), 70'(0));
        chk("rst.ext_vld", 70'(ext_rd_valid), 70'(0));
        chk("rst.ext_rd",  70'(ext_rd), 70'(0));
        creq = '0; ereq = '0;
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;

        // ext_of: 1 wr40, 2 rd40, 3 rd14 ; core_of: 1 rd100, 2 rd10, 3 wr200
        add(1, 0, 0, 1, 32'h0,        0, 32'h0);
        add(0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0);
        add(0, 1, 1, 1, 32'hDEADBEEF, 0, 32'h0);
        add(0, 2, 1, 1, 32'hDEADBEEF, 0, 32'h0);
        add(0, 0, 0, 1, 32'hDEADBEEF, 1, 32'h12345678);
        add(2, 0, 0, 1, 32'hDEADBEEF, 0, 32'h12345678);
        add(0, 3, 1, 1, 32'hAAAA0000, 0, 32'h12345678);
        add(0, 0, 0, 1, 32'hAAAA0000, 1, 32'hBBBB0000);
        add(0, 0, 0, 1, 32'hAAAA0000, 0, 32'hBBBB0000);
        // continuous contention: ext wins every 5th cycle
        add(1, 3, 0, 1, 32'hAAAA0000, 0, 32'hBBBB0000);
        for (int i = 0; i < 3; i++) add(1, 3, 0, 1, 32'hDEADBEEF, 0, 32'hBBBB0000);
        add(1, 3, 1, 0, 32'hDEADBEEF, 0, 32'hBBBB0000);
        add(1, 3, 0, 1, 32'hDEADBEEF, 1, 32'hBBBB0000);
        for (int i = 0; i < 3; i++) add(1, 3, 0, 1, 32'hDEADBEEF, 0, 32'hBBBB0000);
        add(1, 3, 1, 0, 32'hDEADBEEF, 0, 32'hBBBB0000);
        add(0, 0, 0, 1, 32'hDEADBEEF, 1, 32'hBBBB0000);
        // two losses, drop, then a full STARVE_MAX losses again before the grant
        add(3, 3, 0, 1, 32'hDEADBEEF, 0, 32'hBBBB0000);
        add(3, 3, 0, 1, 32'hDEADBEEF, 0, 32'hBBBB0000);
        add(3, 0, 0, 1, 32'hDEADBEEF, 0, 32'hBBBB0000);
        for (int i = 0; i < 4; i++) add(3, 3, 0, 1, 32'hDEADBEEF, 0, 32'hBBBB0000);
        add(3, 3, 1, 0, 32'hDEADBEEF, 0, 32'hBBBB0000);
        add(0, 0, 0, 1, 32'hDEADBEEF, 1, 32'hBBBB0000);

        foreach (tbl[i]) begin
            creq = tbl[i].c; ereq = tbl[i].e;
            #4;
            chk($sformatf("vec%0d.ext_gnt", i),    70'(ext_gnt),      70'(tbl[i].gnt));
            chk($sformatf("vec%0d.core_ready", i), 70'(core_ready),   70'(tbl[i].rdy));
            chk($sformatf("vec%0d.core_rd", i),    70'(core_rd),      70'(tbl[i].cd));
            chk($sformatf("vec%0d.ext_vld", i),    70'(ext_rd_valid), 70'(tbl[i].evld));
            if (tbl[i].evld)
                chk($sformatf("vec%0d.ext_rd", i), 70'(ext_rd), 70'(tbl[i].ed));
            model_eval();
            check_all($sformatf("vec%0d.model", i));
            model_commit();
            @(posedge clk); #1;
        end

        // mid-flight reset: core read issued, reset before its data returns
        creq = core_of(1); ereq = '0;
        cycle("mid.issue");
        creq = core_of(1); ereq = ext_of(3);
        #1 rst = 1'b0;
        #1;
        chk("mid.ext_gnt",    70'(ext_gnt),    70'(0));
        chk("mid.core_ready", 70'(core_ready), 70'(1));
        chk("mid.enables",    70'({arb.rd_en, arb.wr_en}), 70'(0));
        chk("mid.core_rd",    70'(core_rd),    70'(0));
        chk("mid.ext_vld",    70'(ext_rd_valid), 70'(0));
        creq = '0; ereq = '0;
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("mid.after_core_rd", 70'(core_rd), 70'(0));
        chk("mid.after_ext_rd",  70'(ext_rd),  70'(0));
        cycle("mid.idle");

        // randomized traffic; core holds while stalled, ext holds until granted (may drop)
        rc = '0; re = '0; last_rdy = 1'b1; last_eg = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (last_rdy) rc = rnd_req(60);
            if (!is_v(re) || last_eg) re = rnd_req(40);
            else if ($urandom_range(0, 9) == 0) re = '0;
            creq = rc; ereq = re;
            #4;
            model_eval();
            check_all($sformatf("rnd%0d", i));
            last_rdy = x_rdy; last_eg = x_eg;
            model_commit();
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_dmem_arb.md
# rv_dmem_arb

Two-requester arbiter for the single-ported data memory (D_MEM). It sits between the Memory Access stage's request output (`core2dmem_req_Q103H`) and D_MEM, and shares the port with one external requester (debug/loader). It issues at most one access per cycle, stalls the core pipeline through `core_ready_Q104H` when the core loses arbitration, and uses a starvation counter to bound how long the external requester waits. It tracks read ownership so that read data returns to the requester that issued the read.

## Interface
Parameters:
- `STARVE_MAX`, default 4: number of consecutive lost cycles after which a pending external request wins. Legal range 1–15.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `core2dmem_req_Q103H`  in  t_core2mem_req  core request; valid when `rd_en | wr_en`.
- `ext_req`  in  t_core2mem_req  external request; valid when `rd_en | wr_en`; held stable until granted.
- `ext_gnt`  out  1  external request accepted this cycle (combinational).
- `arb2dmem_req`  out  t_core2mem_req  request driven to D_MEM.
- `dmem_rd_data`  in  32  D_MEM read data, valid one cycle after a read is issued.
- `core_ready_Q104H`  out  1  0 = core request not accepted; core holds Q103H and retries.
- `core_rd_data_Q104H`  out  32  load data returned to the core.
- `ext_rd_valid`  out  1  `ext_rd_data` is valid this cycle.
- `ext_rd_data`  out  32  read data returned to the external requester.

## Operation
- Each cycle, grant goes to at most one requester:
  - Core only valid: grant core.
  - External only valid: grant external.
  - Both valid and `starve_cnt == STARVE_MAX`: grant external.
  - Both valid otherwise: grant core.
  - Neither valid: no grant; `arb2dmem_req` is all-zero, so `wr_en = rd_en = 0`.
- `arb2dmem_req` is the winner's struct, passed through unmodified (address, wr_data, byte_en, wr_en, rd_en).
- `ext_gnt` = external valid and external granted.
- `core_ready_Q104H` = 0 only when the core is valid and the external requester is granted; otherwise 1.
- `starve_cnt` (4 bits):
  - Cleared on an external grant, or when the external requester is not valid.
  - Incremented when the external requester is valid but loses.
  - Saturates at `STARVE_MAX`.
- `rd_owner_q` (2 bits: NONE / CORE / EXT) registers the owner of a read issued this cycle; NONE if no read was issued.
- Read return:
  - `core_rd_data_Q104H` = `dmem_rd_data` when `rd_owner_q == CORE`; otherwise it holds its last value.
  - `ext_rd_valid` = (`rd_owner_q == EXT`).
  - `ext_rd_data` = `dmem_rd_data` when `ext_rd_valid`; otherwise it holds its last value.
- Writes return nothing. A write issued in cycle N is visible to a read issued in cycle N+1 or later, from either requester.
- A request with both `rd_en` and `wr_en` set is passed through as-is. Only `rd_en` sets `rd_owner_q`.

## Timing
- Arbitration and the `ext_gnt` / `core_ready_Q104H` / `arb2dmem_req` outputs are combinational in cycle N.
- Read data for a read issued in cycle N is available in cycle N+1.
- Back-to-back reads from alternating owners are supported with no bubble.
- Worst-case external wait is `STARVE_MAX` cycles of loss; the grant comes on the cycle after the last loss.
- Worst-case core stall is 1 cycle per external grant. Consecutive external grants require the starvation counter to refill, so the core stalls at most 1 of every `STARVE_MAX+1` cycles under continuous contention.
- Reset values:
  - `starve_cnt` = 0, `rd_owner_q` = NONE, `ext_rd_valid` = 0.
  - `core_rd_data_Q104H` = 0, `ext_rd_data` = 0.
- While `rst` is low:
  - `ext_gnt` = 0, `core_ready_Q104H` = 1.
  - `arb2dmem_req` enables are forced to 0.
- Reset asserted with a read in flight: the read data is dropped. After reset is released, neither requester receives it.
- If the external requester drops valid before being granted: no grant, and `starve_cnt` returns to 0.

## Test plan
- Core-only load: core read at 0x100, D_MEM holds 0xDEADBEEF → `core_ready_Q104H` = 1 throughout; `core_rd_data_Q104H` = 0xDEADBEEF one cycle later.
- External-only store then load: external write 0x12345678 to 0x40, then external read of 0x40 → `ext_gnt` = 1 on both cycles; `ext_rd_valid` = 1 with 0x12345678 one cycle after the read.
- Contention with `STARVE_MAX` = 4: both requesters continuously valid → core wins 4 cycles, external wins the 5th with `core_ready_Q104H` = 0 in that cycle; the pattern repeats every 5 cycles.
- Ownership interleave: core read of 0x10 (0xAAAA0000) in cycle N, external read of 0x14 (0xBBBB0000) in cycle N+1 → core receives 0xAAAA0000 in N+1; `ext_rd_valid` is high with 0xBBBB0000 in N+2 only.
- Starvation counter reset: external valid for 2 losing cycles, then drops, then reasserts → `starve_cnt` = 0 after the drop; 4 more losses are needed before the external requester is granted.
- Mid-flight reset: core read issued, `rst` pulsed low before the next edge → `core_rd_data_Q104H` = 0, `ext_rd_valid` = 0, `rd_owner_q` = NONE after release.
